// File: rtl/sigmoid_pkg.sv
// Shared constants for the piecewise-linear sigmoid front end and evaluator.
// Q8.8 format, segment saturation index and the per-segment coefficient table.
package sigmoid_pkg;
  localparam int BITS    = 16;
  localparam int FRAC    = 8;
  localparam int SEG_SAT = 6;

  localparam logic [BITS-1:0] ONE_Q88 = 16'h0100;
  localparam logic [BITS-1:0] ABS_MAX = 16'h7FFF;

  localparam logic [BITS-1:0] SEG_GRAD [0:6] = '{
    16'h003B, 16'h0026, 16'h0012, 16'h0008, 16'h0003, 16'h0001, 16'h0000
  };
  localparam logic [BITS-1:0] SEG_OFFS [0:6] = '{
    16'h0080, 16'h0090, 16'h00BD, 16'h00DD, 16'h00F0, 16'h00F9, ONE_Q88
  };
endpackage

// File: rtl/sigmoid_coef_rom.sv
// Combinational coefficient lookup: segment index -> gradient/offset pair.
// Index 7 cannot be produced upstream; it falls back to the saturation entry.
module sigmoid_coef_rom
  import sigmoid_pkg::*;
(
  input  logic [2:0]      seg,
  output logic [BITS-1:0] gradient,
  output logic [BITS-1:0] offset
);

  always_comb begin
    gradient = SEG_GRAD[SEG_SAT];
    offset   = SEG_OFFS[SEG_SAT];
    case (seg)
      3'd0: begin gradient = SEG_GRAD[0]; offset = SEG_OFFS[0]; end
      3'd1: begin gradient = SEG_GRAD[1]; offset = SEG_OFFS[1]; end
      3'd2: begin gradient = SEG_GRAD[2]; offset = SEG_OFFS[2]; end
      3'd3: begin gradient = SEG_GRAD[3]; offset = SEG_OFFS[3]; end
      3'd4: begin gradient = SEG_GRAD[4]; offset = SEG_OFFS[4]; end
      3'd5: begin gradient = SEG_GRAD[5]; offset = SEG_OFFS[5]; end
      default: ;
    endcase
  end

endmodule

// File: rtl/sigmoid_seg_select.sv
// Sigmoid front end: |x|, segment pick and coefficient fetch in a two-stage
// valid/ready pipeline with full throughput and no skid buffer.
module sigmoid_seg_select
  import sigmoid_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [BITS-1:0] x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITS-1:0]        x_abs,
  output logic [BITS-1:0]        gradient,
  output logic [BITS-1:0]        offset,
  output logic                   neg,
  output logic [2:0]             seg
);

  logic            vld_p1, vld_p2;
  logic            neg_p1, neg_p2;
  logic [BITS-1:0] abs_p1, abs_p2, grad_p2, offs_p2;
  logic [2:0]      seg_p1, seg_p2;
  logic [BITS-1:0] abs_x, rom_grad, rom_offs;
  logic [2:0]      seg_x;
  logic            s1_take, s2_take;

  // The most negative code has no positive twin, so it clamps to ABS_MAX.
  function automatic logic [BITS-1:0] sat_abs(input logic signed [BITS-1:0] v);
    if (v == {1'b1, {(BITS-1){1'b0}}})
      return ABS_MAX;
    else if (v < 0)
      return -v;
    return v;
  endfunction

  always_comb begin
    abs_x = sat_abs(x);
    seg_x = abs_x[FRAC+2:FRAC];
    if (abs_x[BITS-1:FRAC] >= (BITS-FRAC)'(SEG_SAT))
      seg_x = 3'(SEG_SAT);
  end

  assign s2_take  = !vld_p2 || out_ready;
  assign s1_take  = !vld_p1 || s2_take;
  assign in_ready = s1_take;

  // Stage 1: sign, magnitude and segment index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      abs_p1 <= '0;
      neg_p1 <= 1'b0;
      seg_p1 <= '0;
    end else if (s1_take) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        abs_p1 <= abs_x;
        neg_p1 <= x[BITS-1];
        seg_p1 <= seg_x;
      end
    end
  end

  sigmoid_coef_rom u_rom (
    .seg      (seg_p1),
    .gradient (rom_grad),
    .offset   (rom_offs)
  );

  // Stage 2: register magnitude with its looked-up coefficients.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      abs_p2  <= '0;
      grad_p2 <= '0;
      offs_p2 <= '0;
      neg_p2  <= 1'b0;
      seg_p2  <= '0;
    end else if (s2_take) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        abs_p2  <= abs_p1;
        grad_p2 <= rom_grad;
        offs_p2 <= rom_offs;
        neg_p2  <= neg_p1;
        seg_p2  <= seg_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign x_abs     = abs_p2;
  assign gradient  = grad_p2;
  assign offset    = offs_p2;
  assign neg       = neg_p2;
  assign seg       = seg_p2;

endmodule

// File: doc/sigmoid_seg_select.md
Name: sigmoid_seg_select

Overview:
Upstream feeder for the piecewise-linear sigmoid evaluator. Accepts a stream of signed Q8.8 samples with valid/ready handshake. For each sample it computes |x|, picks the linear segment and fetches the segment's gradient/offset from an internal constant ROM. It then presents x_abs, gradient, offset and a sign flag to the evaluator. The evaluator output is mirrored downstream (1 - alfa) when neg is set.

Parameters:
BITS, 16, data width; Q8.8 fixed point (FRAC = 8 fixed in package); only 16 supported
NSEG, 7, number of segments (6 linear + 1 saturation); fixed

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  sample x valid
in_ready  output  1  block can accept x this cycle
x  input  BITS  signed Q8.8 input sample
out_valid  output  1  x_abs/gradient/offset/neg valid
out_ready  input  1  downstream accepts this cycle
x_abs  output  BITS  |x|, unsigned Q8.8, saturated to 0x7FFF
gradient  output  BITS  Q8.8 segment gradient
offset  output  BITS  Q8.8 segment offset
neg  output  1  original x was negative
seg  output  3  selected segment index 0..6 (debug/verification)

Behaviour:
- Reset (asynchronous, active-high): s1_valid = 0, s2_valid = 0, so out_valid = 0. x_abs, gradient, offset, neg and seg all reset to 0. in_ready is 1 once rst deasserts.
- Two-stage pipeline; latency is 2 cycles from input acceptance to out_valid when unstalled; throughput is 1 sample/cycle.
- Stage 1 (register on in_valid & in_ready):
  - neg = x[15].
  - abs = neg ? -x : x; x = 0x8000 saturates to 0x7FFF.
  - seg = (abs[15:8] >= 6) ? 6 : abs[10:8].
- Stage 2: registers s1 data and ROM lookup by seg. Gradient/offset per segment:
  - seg 0, |x| in [0,1): 0x003B / 0x0080
  - seg 1, [1,2): 0x0026 / 0x0090
  - seg 2, [2,3): 0x0012 / 0x00BD
  - seg 3, [3,4): 0x0008 / 0x00DD
  - seg 4, [4,5): 0x0003 / 0x00F0
  - seg 5, [5,6): 0x0001 / 0x00F9
  - seg 6, >= 6: 0x0000 / 0x0100
- Handshake:
  - s2_take = !s2_valid | out_ready.
  - s1_take = !s1_valid | s2_take.
  - in_ready = s1_take (combinational chain, no skid buffer).
  - Outputs must hold stable while out_valid & !out_ready.
  - When s2_take is asserted, s2_valid <= s1_valid.
  - When s1_take is asserted, s1_valid <= in_valid.
- Simultaneous accept in and emit out in the same cycle: both occur; there are no bubbles under continuous flow.
- Ordering: strictly FIFO; no sample is dropped or duplicated under any out_ready pattern.
- Boundaries:
  - 0x05FF -> seg 5; 0x0600 -> seg 6.
  - 0xFF01 (-0.996) -> abs 0x00FF, seg 0, neg 1.
  - 0x0000 -> neg 0.
- Reset mid-operation: in-flight samples are discarded and out_valid drops immediately (asynchronous).

Decomposition:
- Package sigmoid_pkg holds:
  - BITS = 16 and FRAC = 8
  - SEG_SAT = 6
  - the coefficient arrays SEG_GRAD[0:6] and SEG_OFFS[0:6]
  - ONE_Q88 = 0x0100 and ABS_MAX = 0x7FFF
- The evaluator reuses the same package.
- One sub-module, sigmoid_coef_rom: combinational lookup seg -> {gradient, offset}, instantiated in stage 2.

Test Plan:
- x = 0x0000, out_ready = 1 -> 2 cycles later out_valid = 1, x_abs = 0x0000, gradient = 0x003B, offset = 0x0080, neg = 0, seg = 0.
- Stream 0x0100, 0x0200, 0x0300, 0x0400, 0x0500 back-to-back -> five outputs on consecutive cycles. Gradients 0x26, 0x12, 0x08, 0x03, 0x01; offsets 0x90, 0xBD, 0xDD, 0xF0, 0xF9.
- Negative and saturation cases:
  - x = 0xFF00 -> x_abs 0x0100, seg 1, neg 1.
  - x = 0x8000 -> x_abs 0x7FFF, seg 6, gradient 0x0000, offset 0x0100, neg 1.
  - x = 0x05FF -> seg 5; x = 0x0600 -> seg 6.
- Backpressure: out_ready = 0 while feeding A, B, C -> in_ready falls after A and B are held. Outputs stay at A until out_ready = 1, then A, B, C emerge in order, with no loss or duplicates.
- Random in_valid/out_ready for 1000 samples vs a reference model -> every output matches, in order.
- Assert rst with two samples in flight -> out_valid = 0 in the same cycle. After release no stale sample appears, and the first new input appears 2 cycles after acceptance.
